// File: rtl/hs_npu_pkg.sv
// Shared NPU types, default widths and the requantisation helper used by the
// matrix-multiply result deskew stage.
package hs_npu_pkg;

  localparam int SIZE_DEF       = 8;
  localparam int IN_WIDTH_DEF   = 32;
  localparam int OUT_WIDTH_DEF  = 16;
  localparam int LANE_DEPTH_DEF = 16;

  typedef logic [4:0] shift_t;

  localparam logic signed [IN_WIDTH_DEF-1:0] SAT_MAX =
    IN_WIDTH_DEF'((64'sd1 <<< (OUT_WIDTH_DEF-1)) - 64'sd1);
  localparam logic signed [IN_WIDTH_DEF-1:0] SAT_MIN = -SAT_MAX - IN_WIDTH_DEF'(1);

  // Floor shift, optional ReLU, then clamp into the signed output range.
  function automatic logic [OUT_WIDTH_DEF-1:0] saturate_relu(
    input logic signed [IN_WIDTH_DEF-1:0] acc,
    input shift_t                         sh,
    input logic                           relu
  );
    logic signed [IN_WIDTH_DEF-1:0] t;
    t = acc >>> sh;
    if (relu && t[IN_WIDTH_DEF-1]) t = '0;
    if (t > SAT_MAX)
      return {1'b0, {(OUT_WIDTH_DEF-1){1'b1}}};
    else if (t < SAT_MIN)
      return {1'b1, {(OUT_WIDTH_DEF-1){1'b0}}};
    else
      return t[OUT_WIDTH_DEF-1:0];
  endfunction

endpackage

// File: rtl/hs_npu_deskew_lane.sv
// Single-lane synchronous FIFO; a push into a full lane is still accepted
// when the same cycle also pops, otherwise it is reported as dropped.
module hs_npu_deskew_lane #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hs_npu_mm_deskew.sv
// Realigns the staggered per-column matrix-multiply results into full rows,
// requantises them and presents them on a valid/ready row interface.
module hs_npu_mm_deskew
  import hs_npu_pkg::*;
#(
  parameter int SIZE       = SIZE_DEF,
  parameter int IN_WIDTH   = IN_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int LANE_DEPTH = LANE_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [SIZE-1:0][IN_WIDTH-1:0]  data_i,
  input  logic [SIZE-1:0]                valid_i,
  input  shift_t                         shift_i,
  input  logic                           relu_en,
  output logic [SIZE-1:0][OUT_WIDTH-1:0] row_o,
  output logic                           row_valid_o,
  input  logic                           row_ready_i,
  output logic                           overflow_o,
  output logic [15:0]                    rows_out_o
);

  logic [SIZE-1:0][IN_WIDTH-1:0]  lane_head;
  logic [SIZE-1:0][OUT_WIDTH-1:0] req_row;
  logic [SIZE-1:0]                lane_empty;
  logic [SIZE-1:0]                lane_full;
  logic [SIZE-1:0]                lane_drop;
  logic                           all_ready;
  logic                           load;
  logic                           transfer;

  assign all_ready = ~|lane_empty;
  assign load      = all_ready && (!row_valid_o || row_ready_i);
  assign transfer  = row_valid_o && row_ready_i;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    hs_npu_deskew_lane #(
      .WIDTH (IN_WIDTH),
      .DEPTH (LANE_DEPTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (valid_i[i]),
      .push_data (data_i[i]),
      .pop       (load),
      .head      (lane_head[i]),
      .empty     (lane_empty[i]),
      .full      (lane_full[i]),
      .drop      (lane_drop[i])
    );

    assign req_row[i] = saturate_relu(lane_head[i], shift_i, relu_en);
  end

  // Output register: a new row may replace the current one in the same
  // cycle it is handed off, giving one row per cycle under steady ready.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      row_valid_o <= 1'b0;
      row_o       <= '0;
    end else if (load) begin
      row_valid_o <= 1'b1;
      row_o       <= req_row;
    end else if (row_ready_i) begin
      row_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      overflow_o <= 1'b0;
    end else if (|lane_drop) begin
      overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_out_o <= '0;
    end else if (transfer && !flush) begin
      rows_out_o <= rows_out_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_hs_npu_mm_deskew.sv
// Directed self-checking bench for the matrix-multiply row deskew stage.
module tb_hs_npu_mm_deskew;

  localparam int SIZE  = 8;
  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int DEPTH = 16;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       flush;
  logic [SIZE-1:0][IN_W-1:0]  data_i;
  logic [SIZE-1:0]            valid_i;
  logic [4:0]                 shift_i;
  logic                       relu_en;
  logic [SIZE-1:0][OUT_W-1:0] row_o;
  logic                       row_valid_o;
  logic                       row_ready_i;
  logic                       overflow_o;
  logic [15:0]                rows_out_o;

  int n_tests  = 0;
  int n_fail   = 0;
  int exp_rows = 0;

  hs_npu_mm_deskew #(
    .SIZE       (SIZE),
    .IN_WIDTH   (IN_W),
    .OUT_WIDTH  (OUT_W),
    .LANE_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .shift_i     (shift_i),
    .relu_en     (relu_en),
    .row_o       (row_o),
    .row_valid_o (row_valid_o),
    .row_ready_i (row_ready_i),
    .overflow_o  (overflow_o),
    .rows_out_o  (rows_out_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = '0;
    data_i  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; row_ready_i = 1'b0; shift_i = '0; relu_en = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if (row_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", row_valid_o); end
    n_tests++;
    if (row_o !== '0) begin n_fail++; $display("[TB] FAIL reset_row: got %h expected 0", row_o); end
    n_tests++;
    if (overflow_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_o); end
    n_tests++;
    if (rows_out_o !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_rows_out: got %0d expected 0", rows_out_o); end
  endtask

  task automatic test_single_row();
    logic [SIZE-1:0][OUT_W-1:0] exp_row;
    row_ready_i = 1'b1;
    for (int c = 0; c < SIZE; c++) begin
      idle();
      valid_i[c] = 1'b1;
      data_i[c]  = IN_W'(100 + c);
      tick();
    end
    idle();
    n_tests++;
    if (row_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_valid: got %b expected 0", row_valid_o); end
    tick();
    for (int i = 0; i < SIZE; i++) exp_row[i] = OUT_W'(100 + i);
    n_tests++;
    if (row_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid: got %b expected 1", row_valid_o); end
    n_tests++;
    if (row_o !== exp_row) begin n_fail++; $display("[TB] FAIL single_row: got %h expected %h", row_o, exp_row); end
    tick();
    exp_rows++;
    n_tests++;
    if (row_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL single_valid_drop: got %b expected 0", row_valid_o); end
    n_tests++;
    if (rows_out_o !== 16'(exp_rows)) begin n_fail++; $display("[TB] FAIL single_rows_out: got %0d expected %0d", rows_out_o, exp_rows); end
  endtask

  task automatic test_stall();
    logic [SIZE-1:0][OUT_W-1:0] exp_row;
    logic [SIZE-1:0][OUT_W-1:0] prev_row;
    logic                       prev_hold;
    int                         n_rx;
    n_rx = 0;
    prev_hold = 1'b0;
    prev_row = '0;
    for (int c = 0; c < 40; c++) begin
      idle();
      for (int i = 0; i < SIZE; i++) begin
        if (c >= i && c - i < 4) begin
          valid_i[i] = 1'b1;
          data_i[i]  = IN_W'((c - i) * 16 + i + 1);
        end
      end
      row_ready_i = !(c >= 5 && c <= 12);
      if (prev_hold) begin
        n_tests++;
        if (row_valid_o !== 1'b1 || row_o !== prev_row) begin
          n_fail++;
          $display("[TB] FAIL stall_hold c=%0d: got valid=%b row=%h expected valid=1 row=%h", c, row_valid_o, row_o, prev_row);
        end
      end
      if (row_valid_o && row_ready_i) begin
        n_tests++;
        if (n_rx >= 4) begin
          n_fail++;
          $display("[TB] FAIL stall_extra_row: got row %0d expected at most 4 rows", n_rx + 1);
        end else begin
          for (int i = 0; i < SIZE; i++) exp_row[i] = OUT_W'(n_rx * 16 + i + 1);
          if (row_o !== exp_row) begin
            n_fail++;
            $display("[TB] FAIL stall_row%0d: got %h expected %h", n_rx, row_o, exp_row);
          end
        end
        n_rx++;
      end
      prev_hold = row_valid_o && !row_ready_i;
      prev_row  = row_o;
      tick();
    end
    idle();
    exp_rows += 4;
    n_tests++;
    if (n_rx !== 4) begin n_fail++; $display("[TB] FAIL stall_row_count: got %0d expected 4", n_rx); end
    n_tests++;
    if (overflow_o !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_overflow: got %b expected 0", overflow_o); end
    n_tests++;
    if (rows_out_o !== 16'(exp_rows)) begin n_fail++; $display("[TB] FAIL stall_rows_out: got %0d expected %0d", rows_out_o, exp_rows); end
  endtask

  task automatic test_requant();
    logic [SIZE-1:0][IN_W-1:0]  din;
    logic [SIZE-1:0][OUT_W-1:0] exp_row;
    int exp_plain [SIZE] = '{4096, -1, 32767, -32768, 0, -1, 2500, -2500};
    int exp_relu  [SIZE] = '{4096, 0, 32767, 0, 0, 0, 2500, 0};
    din[0] = 32'h0001_0000;
    din[1] = 32'hFFFF_FFFB;
    din[2] = 32'h7FFF_FFFF;
    din[3] = 32'h8000_0000;
    din[4] = 32'd3;
    din[5] = 32'hFFFF_FFFF;
    din[6] = 32'd40000;
    din[7] = 32'hFFFF_63C0;
    row_ready_i = 1'b1;
    shift_i = 5'd4;
    for (int pass = 0; pass < 2; pass++) begin
      relu_en = (pass == 1);
      valid_i = '1;
      data_i  = din;
      tick();
      idle();
      tick();
      for (int i = 0; i < SIZE; i++)
        exp_row[i] = (pass == 1) ? OUT_W'(exp_relu[i]) : OUT_W'(exp_plain[i]);
      n_tests++;
      if (row_valid_o !== 1'b1 || row_o !== exp_row) begin
        n_fail++;
        $display("[TB] FAIL requant_relu%0d: got valid=%b row=%h expected valid=1 row=%h", pass, row_valid_o, row_o, exp_row);
      end
      tick();
      exp_rows++;
    end
    shift_i = '0;
    relu_en = 1'b0;
    n_tests++;
    if (rows_out_o !== 16'(exp_rows)) begin n_fail++; $display("[TB] FAIL requant_rows_out: got %0d expected %0d", rows_out_o, exp_rows); end
  endtask

  task automatic test_overflow_flush();
    logic [SIZE-1:0][OUT_W-1:0] exp_row;
    row_ready_i = 1'b0;
    for (int k = 0; k <= DEPTH; k++) begin
      idle();
      valid_i[0] = 1'b1;
      data_i[0]  = IN_W'(k);
      tick();
      if (k == DEPTH - 1) begin
        n_tests++;
        if (overflow_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_before_full: got %b expected 0", overflow_o); end
      end
    end
    idle();
    n_tests++;
    if (overflow_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow_o); end
    tick(); tick();
    n_tests++;
    if (overflow_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow_o); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (overflow_o !== 1'b0 || row_valid_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_clear: got overflow=%b valid=%b expected 0 0", overflow_o, row_valid_o);
    end
    n_tests++;
    if (rows_out_o !== 16'(exp_rows)) begin n_fail++; $display("[TB] FAIL flush_rows_out: got %0d expected %0d", rows_out_o, exp_rows); end
    row_ready_i = 1'b1;
    for (int i = 1; i < SIZE; i++) begin
      valid_i[i] = 1'b1;
      data_i[i]  = IN_W'(200 + i);
    end
    tick();
    idle();
    tick(); tick();
    n_tests++;
    if (row_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_lane0_empty: got valid=%b expected 0", row_valid_o); end
    valid_i[0] = 1'b1;
    data_i[0]  = IN_W'(42);
    tick();
    idle();
    tick();
    exp_row[0] = OUT_W'(42);
    for (int i = 1; i < SIZE; i++) exp_row[i] = OUT_W'(200 + i);
    n_tests++;
    if (row_valid_o !== 1'b1 || row_o !== exp_row) begin
      n_fail++;
      $display("[TB] FAIL flush_fresh_row: got valid=%b row=%h expected valid=1 row=%h", row_valid_o, row_o, exp_row);
    end
    tick();
    exp_rows++;
  endtask

  task automatic test_full_push_pop();
    int start_rows;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    start_rows = exp_rows;
    row_ready_i = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      valid_i[i] = 1'b1;
      data_i[i]  = IN_W'(500 + i);
    end
    tick();
    idle();
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      idle();
      valid_i[0] = 1'b1;
      data_i[0]  = IN_W'(k);
      if (k == 0) begin
        for (int i = 1; i < SIZE; i++) begin
          valid_i[i] = 1'b1;
          data_i[i]  = IN_W'(600);
        end
      end
      tick();
    end
    idle();
    valid_i[0] = 1'b1;
    data_i[0]  = IN_W'(DEPTH);
    row_ready_i = 1'b1;
    tick();
    idle();
    n_tests++;
    if (overflow_o !== 1'b0) begin n_fail++; $display("[TB] FAIL fullpp_overflow: got %b expected 0", overflow_o); end
    n_tests++;
    if (row_valid_o !== 1'b1 || row_o[0] !== OUT_W'(0) || row_o[1] !== OUT_W'(600)) begin
      n_fail++;
      $display("[TB] FAIL fullpp_first_row: got valid=%b lane0=%0d lane1=%0d expected 1 0 600", row_valid_o, row_o[0], row_o[1]);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      for (int i = 1; i < SIZE; i++) begin
        valid_i[i] = 1'b1;
        data_i[i]  = IN_W'(600 + k);
      end
      tick();
      idle();
      tick();
      n_tests++;
      if (row_valid_o !== 1'b1 || row_o[0] !== OUT_W'(k) || row_o[7] !== OUT_W'(600 + k)) begin
        n_fail++;
        $display("[TB] FAIL fullpp_drain%0d: got valid=%b lane0=%0d lane7=%0d expected 1 %0d %0d",
                 k, row_valid_o, row_o[0], row_o[7], k, 600 + k);
      end
    end
    tick();
    exp_rows = start_rows + 18;
    n_tests++;
    if (row_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fullpp_end: got valid=%b overflow=%b expected 0 0", row_valid_o, overflow_o);
    end
    n_tests++;
    if (rows_out_o !== 16'(exp_rows)) begin n_fail++; $display("[TB] FAIL fullpp_rows_out: got %0d expected %0d", rows_out_o, exp_rows); end
  endtask

  task automatic test_reset_mid();
    logic [SIZE-1:0][OUT_W-1:0] exp_row;
    row_ready_i = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      valid_i[i] = 1'b1;
      data_i[i]  = IN_W'(700 + i);
    end
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      valid_i[i] = 1'b1;
      data_i[i]  = IN_W'(800);
    end
    tick();
    idle();
    n_tests++;
    if (row_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_pre_valid: got %b expected 1", row_valid_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rows = 0;
    n_tests++;
    if (row_valid_o !== 1'b0 || row_o !== '0 || overflow_o !== 1'b0 || rows_out_o !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL rstmid_outputs: got valid=%b row=%h ovf=%b rows=%0d expected all 0",
               row_valid_o, row_o, overflow_o, rows_out_o);
    end
    row_ready_i = 1'b1;
    for (int c = 0; c < SIZE; c++) begin
      idle();
      valid_i[c] = 1'b1;
      data_i[c]  = IN_W'(900 + c);
      tick();
    end
    idle();
    tick();
    for (int i = 0; i < SIZE; i++) exp_row[i] = OUT_W'(900 + i);
    n_tests++;
    if (row_valid_o !== 1'b1 || row_o !== exp_row) begin
      n_fail++;
      $display("[TB] FAIL rstmid_fresh_row: got valid=%b row=%h expected valid=1 row=%h", row_valid_o, row_o, exp_row);
    end
    tick();
    exp_rows++;
    n_tests++;
    if (rows_out_o !== 16'(exp_rows)) begin n_fail++; $display("[TB] FAIL rstmid_rows_out: got %0d expected %0d", rows_out_o, exp_rows); end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_stall();
    test_requant();
    test_overflow_flush();
    test_full_push_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
